fir_sample_feeder: RTL and testbench



---
 rtl/fir_pkg.sv | 16 +
 rtl/fir_sample_fifo.sv | 56 +++++
 rtl/fir_sample_feeder.sv | 124 ++++++++++++
 tb/tb_fir_sample_feeder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR sample feeder.
package fir_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int DEPTH_DEF = 16;
  localparam int LEN_W_DEF = 10;
  localparam int GAP_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/fir_sample_fifo.sv
// Sync sample FIFO; pop data is the registered head (read-before-write, no bypass).
// Push ignored when full, pop ignored when empty; simultaneous push/pop keeps count.
module fir_sample_fifo
  import fir_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic [SAMPLE_W-1:0] push_dat_i,
  input  logic                pop_i,
  output logic [SAMPLE_W-1:0] head_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [AW:0]         count_o
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         count_q;
  logic                do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Pointers are AW bits wide, so wrap modulo DEPTH falls out of the arithmetic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// Streams frame_len buffered samples to the FIR as single-cycle strobes spaced 1+gap apart.
// First strobe two cycles after start; stalls (sticky underrun) when the FIFO runs dry.
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                in_ready,
  input  logic                start,
  input  logic [LEN_W-1:0]    frame_len,
  input  logic [GAP_W-1:0]    gap,
  output logic [SAMPLE_W-1:0] data,
  output logic                data_valid,
  output logic                busy,
  output logic                done,
  output logic                underrun
);

  localparam int AW = $clog2(DEPTH);

  feeder_state_e       state_q, state_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [GAP_W-1:0]    gap_reg_q, gap_reg_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [SAMPLE_W-1:0] data_q, data_d;
  logic                dvld_q, dvld_d;
  logic                underrun_q, underrun_d;

  logic                pop;
  logic [SAMPLE_W-1:0] fifo_head;
  logic                fifo_full, fifo_empty;
  logic [AW:0]         fifo_count;

  fir_sample_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (in_valid),
    .push_dat_i (in_data),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign in_ready   = ~fifo_full;
  assign data       = data_q;
  assign data_valid = dvld_q;
  assign underrun   = underrun_q;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_GAP);
  assign done       = (state_q == ST_DONE);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gap_reg_d   = gap_reg_q;
    gap_cnt_d   = gap_cnt_q;
    data_d      = data_q;
    dvld_d      = 1'b0;
    underrun_d  = underrun_q;
    pop         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = frame_len;
          gap_reg_d   = gap;
          underrun_d  = 1'b0;
          state_d     = (frame_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // remaining==0 only after the last issue: holds done off until the strobe cycle has passed.
        if (remaining_q == '0) begin
          state_d = ST_DONE;
        end else if (!fifo_empty) begin
          pop         = 1'b1;
          dvld_d      = 1'b1;
          data_d      = fifo_head;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q != LEN_W'(1) && gap_reg_q != '0) begin
            gap_cnt_d = gap_reg_q;
            state_d   = ST_GAP;
          end
        end else begin
          underrun_d = 1'b1;
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q - 1'b1;
        if (gap_cnt_q <= GAP_W'(1)) state_d = ST_RUN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      gap_reg_q   <= '0;
      gap_cnt_q   <= '0;
      data_q      <= '0;
      dvld_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gap_reg_q   <= gap_reg_d;
      gap_cnt_q   <= gap_cnt_d;
      data_q      <= data_d;
      dvld_q      <= dvld_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Randomized bench for fir_sample_feeder against a queue-based FIFO model and frame timing rules.
module tb_fir_sample_feeder;

  localparam int DEPTH = 16;
  localparam int LEN_W = 10;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [15:0]      in_data = '0;
  logic             in_ready;
  logic             start = 1'b0;
  logic [LEN_W-1:0] frame_len = '0;
  logic [GAP_W-1:0] gap = '0;
  logic [15:0]      data;
  logic             data_valid, busy, done, underrun;

  fir_sample_feeder #(.DEPTH(DEPTH), .LEN_W(LEN_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .start(start), .frame_len(frame_len), .gap(gap), .data(data), .data_valid(data_valid),
    .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          strobes = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          strobe_cyc[$];
  logic [15:0] model_q[$];
  logic [15:0] last_data = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: model the push decision, then compare what the DUT issued at this edge.
  task automatic tick();
    bit push;
    push = in_valid && (model_q.size() < DEPTH);
    check("in_ready", {31'd0, in_ready}, {31'd0, model_q.size() < DEPTH});
    @(posedge clk);
    #1;
    cyc++;
    if (data_valid) begin
      strobes++;
      strobe_cyc.push_back(cyc);
      if (model_q.size() == 0) check("issue_from_empty", 32'd1, 32'd0);
      else check("data", {16'd0, data}, {16'd0, model_q.pop_front()});
      last_data = data;
    end else begin
      check("data_hold", {16'd0, data}, {16'd0, last_data});
    end
    if (push) model_q.push_back(in_data);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    start    = 1'b0;
    rst      = 1'b1;
    #1;
    check("rst_data", {16'd0, data}, 32'd0);
    check("rst_dvld", {31'd0, data_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    model_q.delete();
    last_data = '0;
  endtask

  // mode 0: no pushes, 1: random pushes, 2: push every cycle
  task automatic drive_in(input int mode);
    in_valid = (mode == 2) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    in_data  = 16'($urandom);
  endtask

  task automatic preload(input int n);
    while (model_q.size() < n) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Frame with enough buffered data: strobes at t0+1+i*(g+1), done one cycle after the last.
  task automatic run_frame(input int len, input int g, input int mode, input bit poke);
    int t0;
    int exp_done;
    strobe_cyc.delete();
    strobes   = 0;
    done_cnt  = 0;
    frame_len = LEN_W'(len);
    gap       = GAP_W'(g);
    start     = 1'b1;
    drive_in(mode);
    tick();
    start = 1'b0;
    t0 = cyc;
    check("busy_start", {31'd0, busy}, {31'd0, len != 0});
    for (int i = 0; i < 20000 && done_cnt == 0; i++) begin
      drive_in(mode);
      if (poke && i == 2) begin
        start     = 1'b1;
        frame_len = '0;
      end
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    check("done_seen", done_cnt, 1);
    check("strobe_count", strobes, len);
    foreach (strobe_cyc[i]) check("strobe_time", strobe_cyc[i] - t0, 1 + i * (g + 1));
    exp_done = (len == 0) ? 0 : 1 + (len - 1) * (g + 1) + 1;
    check("done_time", done_cyc - t0, exp_done);
    check("underrun_clear", {31'd0, underrun}, 32'd0);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int t0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Pre-load 1..4, back-to-back frame
    for (int v = 1; v <= 4; v++) begin
      in_valid = 1'b1;
      in_data  = 16'(v);
      tick();
    end
    in_valid = 1'b0;
    run_frame(4, 0, 0, 1'b0);

    // Gap pacing with a start pulse injected mid-frame
    preload(3);
    run_frame(3, 2, 0, 1'b1);

    // Full FIFO, refused 17th push, then drain all 16
    preload(DEPTH);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    tick();
    in_valid = 1'b0;
    run_frame(DEPTH, 0, 0, 1'b0);
    check("drained", model_q.size(), 0);

    // Underrun stall then resume
    in_valid = 1'b1;
    in_data  = 16'h1234;
    tick();
    in_valid  = 1'b0;
    strobes   = 0;
    done_cnt  = 0;
    frame_len = LEN_W'(3);
    gap       = '0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("ur_flag", {31'd0, underrun}, 32'd1);
    check("ur_busy", {31'd0, busy}, 32'd1);
    check("ur_strobes", strobes, 1);
    in_valid = 1'b1;
    in_data  = 16'h8000;
    tick();
    in_data = 16'h7FFF;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 50 && done_cnt == 0; i++) tick();
    check("ur_done", done_cnt, 1);
    check("ur_strobes_total", strobes, 3);
    check("ur_sticky", {31'd0, underrun}, 32'd1);

    // frame_len=0 leaves buffered samples for the next frame; start clears underrun
    preload(2);
    run_frame(0, 0, 0, 1'b0);
    check("len0_untouched", model_q.size(), 2);
    run_frame(2, 1, 0, 1'b0);

    // Reset mid-frame with samples buffered
    preload(8);
    frame_len = LEN_W'(8);
    gap       = GAP_W'(3);
    start     = 1'b1;
    tick();
    start    = 1'b0;
    done_cnt = 0;
    repeat (3) tick();
    do_reset();
    check("abort_no_done", done_cnt, 0);
    preload(2);
    run_frame(2, 0, 0, 1'b0);

    // Randomized frames with random upstream traffic
    for (int f = 0; f < 25; f++) begin
      int len, g;
      len = $urandom_range(1, DEPTH);
      g   = $urandom_range(0, 3);
      preload(len);
      run_frame(len, g, 1, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) begin
        drive_in(1);
        tick();
      end
      in_valid = 1'b0;
    end

    // Maximum frame length with continuous feeding
    preload(DEPTH);
    run_frame((1 << LEN_W) - 1, 0, 2, 1'b0);

    t0 = cyc;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
